jk_bank_seq: RTL
================

// Module: jk_bank_seq
// PURPOSE
//  Sequencer for an external bank of WIDTH JK flip-flops (one j/k/q per bit, no reset of their own).
//  Accepts commands over a valid/ready handshake and drives per-bit j/k so the bank loads, sets,
//  clears, toggles, or counts up/down. Clears the bank once after every reset.
//  Sits between the command source and the jk_ff bank; the bank's q vector feeds back as q_in.
// PARAMETERS
//  WIDTH  4  number of JK flip-flops in the bank
//  CNT_W  8  width of the step-count field for count commands
// PORTS
//  clk        in   1      rising-edge clock, shared with the JK bank
//  rst_n      in   1      reset, asynchronous, active-low
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command accepted on clk edge when cmd_valid && cmd_ready
//  cmd_op     in   3      opcode (see BEHAVIOUR)
//  cmd_data   in   WIDTH  load value / bit mask
//  cmd_count  in   CNT_W  number of count steps
//  cmd_abort  in   1      stop an active count early
//  q_in       in   WIDTH  current q of the JK bank
//  jk_j       out  WIDTH  j inputs to the bank
//  jk_k       out  WIDTH  k inputs to the bank
//  busy       out  1      command in progress (incl. INIT)
//  done       out  1      one-cycle pulse: last command's effect is visible on q_in
// BEHAVIOUR
//  Reset: state=INIT. cmd_ready=0, busy=1, done=0, jk_j=0, jk_k=all-ones. Op/mask/remaining regs=0.
//  jk_j/jk_k are combinational from the state and the op/mask registers.
//  In COUNT they also depend on q_in. busy and cmd_ready decode the state. done is registered.
//  States:
//   INIT   One cycle after rst_n rises. Drives j=0, k=1s, so the bank clears on that edge. -> IDLE.
//   IDLE   cmd_ready=1, j=k=0 (bank holds). On accept, capture op/data/count.
//          Single-cycle ops -> EXEC. COUNT_UP/DOWN -> COUNT with rem=cmd_count.
//   EXEC   Applies the op for exactly one cycle -> IDLE. done=1 in the next cycle.
//   COUNT  If rem==0: j=k=0 -> IDLE + done (one busy cycle, no change).
//          Otherwise: apply one step, rem-=1. When the step is made with rem==1 -> IDLE + done.
//  Ops (j,k per bit; m = captured data):
//   000 NOP        j=0, k=0
//   001 LOAD       j=m, k=~m
//   010 SET        j=m, k=0
//   011 CLR        j=0, k=m
//   100 TOG        j=m, k=m
//   101 COUNT_UP   j=k=t, where t[0]=1 and t[i]=&q_in[i-1:0]. Wraps all-ones -> 0.
//   110 COUNT_DN   j=k=t, where t[0]=1 and t[i]=&~q_in[i-1:0]. Wraps 0 -> all-ones.
//   111 reserved   handled as NOP (accepted, 1 EXEC cycle, done pulses).
//  Latency:
//   Single op: accept edge, then EXEC cycle. New q and done appear the cycle after EXEC.
//   COUNT N>=1: N step cycles, then done.
//  cmd_ready is 1 during the done cycle, so back-to-back accept is allowed. Throughput: 1 op per 2 cycles.
//  cmd_abort in COUNT: that cycle j=k=0 (no step), state -> IDLE, done pulses next cycle, rem cleared.
//   Ignored in all other states. Abort and rem==0 together -> single done.
//  cmd_valid while not ready: ignored. cmd_data/op may change freely; only the accept-edge values are used.
//  Reset asserted mid-operation: immediately INIT outputs (k=1s). Command lost, no done.
//   Bank clears on the first edge after release.
// TESTING (WIDTH=4, CNT_W=8)
//  1. Release rst_n with bank q=0x9 -> j=0, k=0xF for one cycle; q=0x0 next; cmd_ready=1, busy=0.
//  2. LOAD data=0xA -> EXEC cycle j=0xA, k=0x5. q=0xA and done=1 two cycles after accept.
//  3. From q=0xA, COUNT_UP count=7 -> busy 7 cycles, q steps B,C,D,E,F,0,1; done with q=0x1.
//  4. From 0x1, COUNT_DN 3 -> q=0x0,0xF,0xE. Then TOG 0x5 -> q=0xB. Then CLR 0x8 -> 0x3, SET 0x4 -> 0x7.
//  5. COUNT_UP 0 -> one busy cycle, q unchanged, done. Op 111 -> q unchanged, done.
//  6. COUNT_UP 200 from 0x0, abort after 5 steps -> q=0x5, done once.
//     Then repeat without abort, pulsing rst_n at step 3 -> no done, q=0x0 after INIT.

Source files
------------

// File: rtl/jk_bank_seq_if.sv
// Command channel into the JK bank sequencer: a valid/ready handshake plus the
// command payload and a side-band abort for an active count.
interface jk_bank_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    // Handshake: a command transfers on the rising clk edge where cmd_valid && cmd_ready.
    // The payload (cmd_op/cmd_data/cmd_count) is sampled only on that edge; cmd_valid
    // while cmd_ready is low is ignored. cmd_abort is not part of the handshake.
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_abort;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_abort,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_seq.sv
// Sequencer driving per-bit j/k of an external JK flip-flop bank: load, set, clear,
// toggle and up/down counting, with a one-time bank clear after every reset.
module jk_bank_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_bank_seq_if.slave     cmd,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_EXEC  = 2'd2,
        S_COUNT = 2'd3
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SET  = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_TOG  = 3'b100;
    localparam logic [2:0] OP_UP   = 3'b101;
    localparam logic [2:0] OP_DN   = 3'b110;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] rem_q;
    logic             done_q;
    logic             accept;
    logic             cnt_stop;
    logic [WIDTH-1:0] t_up, t_dn;

    assign accept   = cmd.cmd_valid && cmd.cmd_ready;
    // A count ends this cycle on abort, on an empty count, or when taking its last step.
    assign cnt_stop = cmd.cmd_abort || (rem_q <= CNT_W'(1));

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            op_q    <= '0;
            mask_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_EXEC) || ((state_q == S_COUNT) && cnt_stop);
            if (accept) begin
                op_q   <= cmd.cmd_op;
                mask_q <= cmd.cmd_data;
                rem_q  <= cmd.cmd_count;
            end else if (state_q == S_COUNT) begin
                if (cmd.cmd_abort || rem_q == '0) rem_q <= '0;
                else                              rem_q <= rem_q - CNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  state_d = S_IDLE;
            S_IDLE:  if (accept) state_d = (cmd.cmd_op == OP_UP || cmd.cmd_op == OP_DN) ? S_COUNT : S_EXEC;
            S_EXEC:  state_d = S_IDLE;
            S_COUNT: if (cnt_stop) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Per-bit toggle enables for a binary count on the bank's current value.
    always_comb begin
        t_up = '0;
        t_dn = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i] = 1'b1;
            t_dn[i] = 1'b1;
            for (int b = 0; b < i; b++) begin
                t_up[i] = t_up[i] & q_in[b];
                t_dn[i] = t_dn[i] & ~q_in[b];
            end
        end
    end

    // Output decode.
    always_comb begin
        jk_j = '0;
        jk_k = '0;
        case (state_q)
            S_INIT: jk_k = '1;
            S_EXEC: begin
                case (op_q)
                    OP_LOAD: begin jk_j = mask_q; jk_k = ~mask_q; end
                    OP_SET:  jk_j = mask_q;
                    OP_CLR:  jk_k = mask_q;
                    OP_TOG:  begin jk_j = mask_q; jk_k = mask_q; end
                    default: ;
                endcase
            end
            S_COUNT: begin
                if (!cmd.cmd_abort && rem_q != '0) begin
                    jk_j = (op_q == OP_DN) ? t_dn : t_up;
                    jk_k = jk_j;
                end
            end
            default: ;
        endcase
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign state_dbg     = state_q;
endmodule
